// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcode, state and flag types for alu_pipe
package alu_pipe_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_NOT = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_ADD = 4'd6,
        OP_SUB = 4'd7,
        OP_ADC = 4'd8,
        OP_SBB = 4'd9,
        OP_MUL = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MBUSY = 2'd1,
        MDONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic err;
    } alu_flags_t;

    // Shifts and the add/subtract family are the only ops that own the carry register.
    function automatic logic writes_cf(input logic [ALU_OP_W-1:0] op);
        return (op >= OP_SHL) && (op <= OP_SBB);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one partial product per cycle
module alu_seq_mul
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Asserted during the cycle whose closing edge adds the last partial product.
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked registered ALU with carry chaining; ALU_PIPE_MUL_EN adds the multiplier
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    res,
    output logic [WIDTH-1:0]    res_hi,
    output logic                carry,
    output logic                zero,
    output logic                neg,
    output logic                ovf,
    output logic                err
);

    alu_state_e       state;
    logic             cf;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    alu_flags_t       flags_q;

    logic             out_free;
    logic             accept;
    logic             is_mul;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] alu_res;
    alu_flags_t       alu_flags;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = rst_n && (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res_hi_q;

    assign is_mul = (op == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    assign res_hi = res_hi_q;
`else
    assign is_mul = 1'b0;
    assign res_hi = '0;
`endif

    always_comb begin
        ext       = '0;
        alu_res   = '0;
        alu_flags = '0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res         = a << 1;
                alu_flags.carry = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res         = b >> 1;
                alu_flags.carry = b[0];
            end
            OP_ADD, OP_ADC: begin
                ext = {1'b0, a} + {1'b0, b}
                    + {{WIDTH{1'b0}}, (op == OP_ADC) ? cf : 1'b0};
                alu_res         = ext[WIDTH-1:0];
                alu_flags.carry = ext[WIDTH];
                alu_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                // Bit WIDTH of the extended difference is the borrow out.
                ext = {1'b0, a} - {1'b0, b}
                    - {{WIDTH{1'b0}}, (op == OP_SBB) ? cf : 1'b0};
                alu_res         = ext[WIDTH-1:0];
                alu_flags.carry = ext[WIDTH];
                alu_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: ;
`endif
            default: alu_flags.err = 1'b1;
        endcase
        if (alu_flags.err) begin
            alu_flags.zero = 1'b1;
        end else begin
            alu_flags.zero = (alu_res == '0);
            alu_flags.neg  = alu_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cf          <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
`ifdef ALU_PIPE_MUL_EN
            res_hi_q    <= '0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MBUSY;
                        end else begin
                            res_q       <= alu_res;
                            flags_q     <= alu_flags;
                            out_valid_q <= 1'b1;
`ifdef ALU_PIPE_MUL_EN
                            res_hi_q    <= '0;
`endif
                            if (writes_cf(op)) begin
                                cf <= alu_flags.carry;
                            end
                        end
                    end
                end
`ifdef ALU_PIPE_MUL_EN
                MBUSY: begin
                    if (mul_done) begin
                        state <= MDONE;
                    end
                end
                MDONE: begin
                    if (out_free) begin
                        res_q         <= product[WIDTH-1:0];
                        res_hi_q      <= product[2*WIDTH-1:WIDTH];
                        flags_q.carry <= 1'b0;
                        flags_q.zero  <= (product == '0);
                        flags_q.neg   <= product[WIDTH-1];
                        flags_q.ovf   <= 1'b0;
                        flags_q.err   <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state         <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign carry     = flags_q.carry;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;
    assign ovf       = flags_q.ovf;
    assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at WIDTH=8
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] res_hi;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic [7:0] res_hi;
    logic       carry;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       err;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    logic mcf = 1'b0;
    logic last_acc = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_hi    (res_hi),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .err       (err)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input logic cin, output logic cwe);
        exp_t e;
        int   s;
        int   ss;
        int   sx;
        int   sy;
        e   = '0;
        cwe = 1'b0;
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: e.res = x ^ y;
            4'd3: e.res = ~x;
            4'd4: begin e.res = {x[6:0], 1'b0}; e.c = x[7]; cwe = 1'b1; end
            4'd5: begin e.res = {1'b0, y[7:1]}; e.c = y[0]; cwe = 1'b1; end
            4'd6, 4'd8: begin
                s  = int'(x) + int'(y) + ((o == 4'd8) ? int'(cin) : 0);
                ss = sx + sy + ((o == 4'd8) ? int'(cin) : 0);
                e.res = 8'(s); e.c = (s > 255); e.v = (ss > 127) || (ss < -128); cwe = 1'b1;
            end
            4'd7, 4'd9: begin
                s  = int'(x) - int'(y) - ((o == 4'd9) ? int'(cin) : 0);
                ss = sx - sy - ((o == 4'd9) ? int'(cin) : 0);
                e.res = 8'(s); e.c = (s < 0); e.v = (ss > 127) || (ss < -128); cwe = 1'b1;
            end
`ifdef ALU_PIPE_MUL_EN
            4'd10: begin
                s = int'(x) * int'(y);
                e.res = 8'(s); e.res_hi = 8'(s >> 8);
            end
`endif
            default: e.e = 1'b1;
        endcase
        if (e.e) begin
            e.z = 1'b1;
        end else if (o == 4'd10) begin
            e.z = ({e.res_hi, e.res} == 16'h0);
            e.n = e.res[7];
        end else begin
            e.z = (e.res == 8'h00);
            e.n = e.res[7];
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: push accepted stimulus into the scoreboard, compare any result consumed at this edge.
    task automatic tick();
        exp_t e;
        exp_t obs;
        logic xfer;
        logic we;
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            e = model(op, a, b, mcf, we);
            q.push_back(e);
            if (we) mcf = e.c;
        end
        xfer = out_valid && out_ready;
        obs  = {res, res_hi, carry, zero, neg, ovf, err};
        @(negedge clk);
        if (xfer) begin
            if (q.size() == 0) begin
                chk("sb_unexpected", 32'(obs), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("sb_result", 32'(obs), 32'(e));
            end
        end
    endtask

    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int n;
        in_valid = 1'b1; op = o; a = x; b = y;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) chk("send_timeout", 32'(n), 32'd0);
    endtask

    logic [19:0] tbl [10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int hits;
        tbl = '{20'h4_81_00, 20'h9_10_05, 20'h5_00_03, 20'h8_7F_00, 20'h2_5A_5A,
                20'h3_00_00, 20'h9_00_01, 20'h1_00_00, 20'hA_00_05, 20'hF_12_34};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = 8'h00; b = 8'h00;
        repeat (3) tick();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({res, res_hi, carry, zero, neg, ovf, err}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        send(4'd6, 8'hF0, 8'h20);
        in_valid = 1'b0;
        chk("add_latency", 32'(out_valid), 32'd1);
        chk("add_res", 32'(res), 32'h10);
        chk("add_flags", 32'({carry, zero, ovf}), 32'b100);
        tick();
        chk("add_drained", 32'(out_valid), 32'd0);

        send(4'd6, 8'hFF, 8'h01);
        chk("add_wrap", 32'({res, zero, carry}), 32'({8'h00, 1'b1, 1'b1}));
        send(4'd8, 8'h00, 8'h00);
        in_valid = 1'b0;
        chk("adc_chain", 32'(res), 32'h01);
        tick();

        send(4'd7, 8'h80, 8'h01);
        in_valid = 1'b0;
        chk("sub_flags", 32'({res, carry, ovf, neg}), 32'({8'h7F, 1'b0, 1'b1, 1'b0}));
        tick();

        out_ready = 1'b0;
        send(4'd0, 8'hCC, 8'hAA);
        in_valid = 1'b1; op = 4'd1; a = 8'h55; b = 8'hF0;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        tick();
        a = 8'h0F;
        tick();
        chk("stall_stable", 32'({res, carry, zero, neg, ovf, err}), 32'({8'h88, 5'b00100}));
        out_ready = 1'b1;
        #1;
        chk("release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("refill_res", 32'({out_valid, res}), 32'({1'b1, 8'hFF}));
        tick();

        foreach (tbl[i]) send(tbl[i][19:16], tbl[i][15:8], tbl[i][7:0]);
        in_valid = 1'b0;
        repeat (2) tick();

        send(4'd10, 8'hFF, 8'hFF);
        in_valid = 1'b0; a = 8'h00; b = 8'h00;
`ifdef ALU_PIPE_MUL_EN
        k = 0;
        hits = 0;
        while (!out_valid && k < 40) begin
            if (in_ready) hits++;
            tick();
            k++;
        end
        chk("mul_latency", 32'(k), 32'd9);
        chk("mul_busy_ready", 32'(hits), 32'd0);
        chk("mul_product", 32'({res_hi, res, err}), 32'({8'hFE, 8'h01, 1'b0}));
`else
        chk("mul_disabled", 32'({out_valid, err, res}), 32'({1'b1, 1'b1, 8'h00}));
`endif
        tick();

        send(4'hC, 8'h12, 8'h34);
        in_valid = 1'b0;
        chk("illegal_op", 32'({err, zero, res}), 32'({1'b1, 1'b1, 8'h00}));
        tick();

        send(4'd4, 8'h80, 8'h00);
        send(4'd10, 8'h03, 8'h05);
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        q.delete();
        mcf = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("rdy_after_abort", 32'(in_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) hits++;
            tick();
        end
        chk("abort_no_result", 32'(hits), 32'd0);

        send(4'd8, 8'h01, 8'h01);
        in_valid = 1'b0;
        chk("cf_cleared", 32'({res, carry}), 32'({8'h02, 1'b0}));
        repeat (2) tick();
        chk("sb_drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
